// File: rtl/axi_shim_arbiter.sv
// axi_shim_arbiter
//   Shares one axi_shim read/write request port pair between NumReq
//   cache-side requesters. Read and write run independent round-robin
//   arbiters that hold their pick until the shim grants. The shim ID is
//   {requester index, local id}, so responses route back by their upper
//   bits. Per-requester outstanding counters throttle eligibility.
//
// Ports (top):
//   clk_i, rst_ni                 clock, async active-low reset
//   rd_*_i / wr_*_i               per-requester requests and payloads
//   rd_gnt_o / wr_gnt_o           per-requester grant (one-hot or zero)
//   rd_valid_o/rd_last_o/rd_data_o/rd_id_o/rd_exokay_o   routed read beats
//   wr_valid_o/wr_id_o/wr_exokay_o                      routed write responses
//   shim_rd_*_o / shim_wr_*_o     muxed request payload and ready to shim
//   shim_rd_*_i / shim_wr_*_i     shim grant and response inputs
//   err_o                         sticky protocol error (illegal id or underflow)

// axi_shim_arb_dir
//   One direction's arbiter: IDLE/HOLD FSM, round-robin pointer, held
//   selection and per-requester outstanding counters. Payload is opaque.
//
// Ports:
//   req_i, pay_i                  per-requester request and packed payload
//   shim_gnt_i                    shim grant for the presented request
//   dec_i, dec_idx_i              one completed transaction for dec_idx_i
//   gnt_o                         per-requester grant
//   shim_req_o, shim_pay_o        presented request and its payload
//   shim_idx_o                    index of the presented requester
//   uflow_o                       decrement hit a zero counter this cycle
module axi_shim_arb_dir #(
    parameter int NumReq   = 3,
    parameter int MaxOutst = 4,
    parameter int PayW     = 8,
    parameter int IdxWidth = $clog2(NumReq)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumReq-1:0]              req_i,
    input  logic [NumReq-1:0][PayW-1:0]    pay_i,
    input  logic                           shim_gnt_i,
    input  logic                           dec_i,
    input  logic [IdxWidth-1:0]            dec_idx_i,
    output logic [NumReq-1:0]              gnt_o,
    output logic                           shim_req_o,
    output logic [PayW-1:0]                shim_pay_o,
    output logic [IdxWidth-1:0]            shim_idx_o,
    output logic                           uflow_o
);
    localparam int CntW = $clog2(MaxOutst + 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                          state_q, state_d;
    logic [IdxWidth-1:0]             ptr_q, ptr_d;
    logic [IdxWidth-1:0]             sel_q, sel_d;
    logic [NumReq-1:0][CntW-1:0]     cnt_q, cnt_d;

    logic                            found;
    logic [IdxWidth-1:0]             pick;
    logic [IdxWidth-1:0]             cur;
    logic                            req_c;
    logic [NumReq-1:0]               gnt_c;

    function automatic logic [IdxWidth-1:0] nxt_idx(input logic [IdxWidth-1:0] idx);
        return (idx == IdxWidth'(NumReq - 1)) ? '0 : idx + 1'b1;
    endfunction

    // First eligible requester at or after ptr, wrapping modulo NumReq.
    always_comb begin
        logic [IdxWidth:0]   s;
        logic [IdxWidth-1:0] j;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NumReq; k++) begin
            s = {1'b0, ptr_q} + (IdxWidth+1)'(k);
            if (s >= (IdxWidth+1)'(NumReq)) s = s - (IdxWidth+1)'(NumReq);
            j = s[IdxWidth-1:0];
            if (!found && req_i[j] && (cnt_q[j] < CntW'(MaxOutst))) begin
                found = 1'b1;
                pick  = j;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        req_c   = 1'b0;
        cur     = pick;
        gnt_c   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_c = 1'b1;
                    if (shim_gnt_i) begin
                        gnt_c[pick] = 1'b1;
                        ptr_d       = nxt_idx(pick);
                    end else begin
                        sel_d   = pick;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Locked onto sel until the shim takes it; no re-arbitration.
                req_c = 1'b1;
                cur   = sel_q;
                if (shim_gnt_i) begin
                    gnt_c[sel_q] = 1'b1;
                    ptr_d        = nxt_idx(sel_q);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Increment on grant, decrement on completion; both at once cancel.
    always_comb begin
        logic dec_hit;
        cnt_d   = cnt_q;
        uflow_o = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            dec_hit = dec_i && (dec_idx_i == IdxWidth'(i));
            if (gnt_c[i] && !dec_hit) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_hit && !gnt_c[i]) begin
                if (cnt_q[i] == '0) uflow_o = 1'b1;
                else                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o      = rst_ni ? gnt_c : '0;
    assign shim_req_o = rst_ni & req_c;
    assign shim_pay_o = pay_i[cur];
    assign shim_idx_o = cur;
endmodule

module axi_shim_arbiter #(
    parameter int NumReq       = 3,
    parameter int AddrWidth    = 64,
    parameter int DataWidth    = 64,
    parameter int LocalIdWidth = 2,
    parameter int MaxOutst     = 4,
    parameter int IdxWidth     = $clog2(NumReq),
    parameter int ShimIdWidth  = IdxWidth + LocalIdWidth
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    // read requests
    input  logic [NumReq-1:0]                       rd_req_i,
    output logic [NumReq-1:0]                       rd_gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]        rd_addr_i,
    input  logic [NumReq-1:0][7:0]                  rd_blen_i,
    input  logic [NumReq-1:0][2:0]                  rd_size_i,
    input  logic [NumReq-1:0][LocalIdWidth-1:0]     rd_id_i,
    input  logic [NumReq-1:0]                       rd_lock_i,
    // write requests
    input  logic [NumReq-1:0]                       wr_req_i,
    output logic [NumReq-1:0]                       wr_gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]        wr_addr_i,
    input  logic [NumReq-1:0][7:0]                  wr_blen_i,
    input  logic [NumReq-1:0][2:0]                  wr_size_i,
    input  logic [NumReq-1:0][LocalIdWidth-1:0]     wr_id_i,
    input  logic [NumReq-1:0]                       wr_lock_i,
    input  logic [NumReq-1:0][DataWidth-1:0]        wr_data_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]      wr_be_i,
    // routed responses
    output logic [NumReq-1:0]                       rd_valid_o,
    output logic [NumReq-1:0]                       rd_last_o,
    input  logic [NumReq-1:0]                       rd_rdy_i,
    output logic [DataWidth-1:0]                    rd_data_o,
    output logic [LocalIdWidth-1:0]                 rd_id_o,
    output logic                                    rd_exokay_o,
    output logic [NumReq-1:0]                       wr_valid_o,
    output logic [LocalIdWidth-1:0]                 wr_id_o,
    output logic                                    wr_exokay_o,
    // shim read request
    output logic                                    shim_rd_req_o,
    input  logic                                    shim_rd_gnt_i,
    output logic [AddrWidth-1:0]                    shim_rd_addr_o,
    output logic [7:0]                              shim_rd_blen_o,
    output logic [2:0]                              shim_rd_size_o,
    output logic [ShimIdWidth-1:0]                  shim_rd_id_o,
    output logic                                    shim_rd_lock_o,
    // shim write request
    output logic                                    shim_wr_req_o,
    input  logic                                    shim_wr_gnt_i,
    output logic [AddrWidth-1:0]                    shim_wr_addr_o,
    output logic [7:0]                              shim_wr_blen_o,
    output logic [2:0]                              shim_wr_size_o,
    output logic [ShimIdWidth-1:0]                  shim_wr_id_o,
    output logic                                    shim_wr_lock_o,
    output logic [DataWidth-1:0]                    shim_wr_data_o,
    output logic [DataWidth/8-1:0]                  shim_wr_be_o,
    // shim responses
    input  logic                                    shim_rd_valid_i,
    input  logic                                    shim_rd_last_i,
    input  logic                                    shim_rd_exokay_i,
    input  logic [DataWidth-1:0]                    shim_rd_data_i,
    input  logic [ShimIdWidth-1:0]                  shim_rd_id_i,
    output logic                                    shim_rd_rdy_o,
    input  logic                                    shim_wr_valid_i,
    input  logic                                    shim_wr_exokay_i,
    input  logic [ShimIdWidth-1:0]                  shim_wr_id_i,
    output logic                                    shim_wr_rdy_o,
    output logic                                    err_o
);
    localparam int RdPayW = AddrWidth + 8 + 3 + LocalIdWidth + 1;
    localparam int WrPayW = RdPayW + DataWidth + DataWidth/8;

    logic [NumReq-1:0][RdPayW-1:0] rd_pay;
    logic [NumReq-1:0][WrPayW-1:0] wr_pay;
    logic [RdPayW-1:0]             shim_rd_pay;
    logic [WrPayW-1:0]             shim_wr_pay;
    logic [IdxWidth-1:0]           rd_sel_idx, wr_sel_idx;
    logic [LocalIdWidth-1:0]       rd_lid, wr_lid;

    for (genvar i = 0; i < NumReq; i++) begin : g_pay
        assign rd_pay[i] = {rd_addr_i[i], rd_blen_i[i], rd_size_i[i], rd_id_i[i], rd_lock_i[i]};
        assign wr_pay[i] = {wr_addr_i[i], wr_blen_i[i], wr_size_i[i], wr_id_i[i], wr_lock_i[i],
                            wr_data_i[i], wr_be_i[i]};
    end

    // ---------------- response routing ----------------
    logic [IdxWidth-1:0] rd_rsp_idx, wr_rsp_idx;
    logic                rd_idx_ok, wr_idx_ok;
    logic                rd_dec, wr_dec, rd_ill, wr_ill;
    logic                rd_uflow, wr_uflow;

    assign rd_rsp_idx = shim_rd_id_i[ShimIdWidth-1 -: IdxWidth];
    assign wr_rsp_idx = shim_wr_id_i[ShimIdWidth-1 -: IdxWidth];
    // Only reachable when NumReq is not a power of two.
    assign rd_idx_ok  = int'(rd_rsp_idx) < NumReq;
    assign wr_idx_ok  = int'(wr_rsp_idx) < NumReq;

    always_comb begin
        rd_valid_o    = '0;
        rd_last_o     = '0;
        wr_valid_o    = '0;
        // Beats with an illegal index are drained so the shim cannot stall.
        shim_rd_rdy_o = 1'b1;
        if (rd_idx_ok) begin
            rd_valid_o[rd_rsp_idx] = rst_ni & shim_rd_valid_i;
            rd_last_o[rd_rsp_idx]  = shim_rd_last_i;
            shim_rd_rdy_o          = rd_rdy_i[rd_rsp_idx];
        end
        if (wr_idx_ok) wr_valid_o[wr_rsp_idx] = rst_ni & shim_wr_valid_i;
    end

    assign shim_wr_rdy_o = 1'b1;
    assign rd_data_o     = shim_rd_data_i;
    assign rd_id_o       = shim_rd_id_i[LocalIdWidth-1:0];
    assign rd_exokay_o   = shim_rd_exokay_i;
    assign wr_id_o       = shim_wr_id_i[LocalIdWidth-1:0];
    assign wr_exokay_o   = shim_wr_exokay_i;

    // A read transaction completes on its accepted last beat.
    assign rd_dec = shim_rd_valid_i & shim_rd_rdy_o & shim_rd_last_i & rd_idx_ok;
    assign wr_dec = shim_wr_valid_i & wr_idx_ok;
    assign rd_ill = shim_rd_valid_i & ~rd_idx_ok;
    assign wr_ill = shim_wr_valid_i & ~wr_idx_ok;

    // ---------------- arbiters ----------------
    axi_shim_arb_dir #(
        .NumReq(NumReq), .MaxOutst(MaxOutst), .PayW(RdPayW), .IdxWidth(IdxWidth)
    ) u_rd_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (rd_req_i),
        .pay_i     (rd_pay),
        .shim_gnt_i(shim_rd_gnt_i),
        .dec_i     (rd_dec),
        .dec_idx_i (rd_rsp_idx),
        .gnt_o     (rd_gnt_o),
        .shim_req_o(shim_rd_req_o),
        .shim_pay_o(shim_rd_pay),
        .shim_idx_o(rd_sel_idx),
        .uflow_o   (rd_uflow)
    );

    axi_shim_arb_dir #(
        .NumReq(NumReq), .MaxOutst(MaxOutst), .PayW(WrPayW), .IdxWidth(IdxWidth)
    ) u_wr_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (wr_req_i),
        .pay_i     (wr_pay),
        .shim_gnt_i(shim_wr_gnt_i),
        .dec_i     (wr_dec),
        .dec_idx_i (wr_rsp_idx),
        .gnt_o     (wr_gnt_o),
        .shim_req_o(shim_wr_req_o),
        .shim_pay_o(shim_wr_pay),
        .shim_idx_o(wr_sel_idx),
        .uflow_o   (wr_uflow)
    );

    assign {shim_rd_addr_o, shim_rd_blen_o, shim_rd_size_o, rd_lid, shim_rd_lock_o} = shim_rd_pay;
    assign {shim_wr_addr_o, shim_wr_blen_o, shim_wr_size_o, wr_lid, shim_wr_lock_o,
            shim_wr_data_o, shim_wr_be_o} = shim_wr_pay;
    assign shim_rd_id_o = {rd_sel_idx, rd_lid};
    assign shim_wr_id_o = {wr_sel_idx, wr_lid};

    // ---------------- sticky error ----------------
    logic err_q, err_d;
    assign err_d = err_q | rd_ill | wr_ill | rd_uflow | wr_uflow;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_o = err_q;
endmodule

// File: tb/tb_axi_shim_arbiter.sv
// Directed bench for axi_shim_arbiter (NumReq=3, MaxOutst=4, defaults).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_axi_shim_arbiter;
    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 2;
    localparam int SW = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic [N-1:0]            rd_req_i, rd_gnt_o, wr_req_i, wr_gnt_o;
    logic [N-1:0][AW-1:0]    rd_addr_i, wr_addr_i;
    logic [N-1:0][7:0]       rd_blen_i, wr_blen_i;
    logic [N-1:0][2:0]       rd_size_i, wr_size_i;
    logic [N-1:0][LW-1:0]    rd_id_i, wr_id_i;
    logic [N-1:0]            rd_lock_i, wr_lock_i;
    logic [N-1:0][DW-1:0]    wr_data_i;
    logic [N-1:0][DW/8-1:0]  wr_be_i;
    logic [N-1:0]            rd_valid_o, rd_last_o, rd_rdy_i, wr_valid_o;
    logic [DW-1:0]           rd_data_o;
    logic [LW-1:0]           rd_id_o, wr_id_o;
    logic                    rd_exokay_o, wr_exokay_o;
    logic                    shim_rd_req_o, shim_rd_gnt_i, shim_rd_lock_o;
    logic [AW-1:0]           shim_rd_addr_o, shim_wr_addr_o;
    logic [7:0]              shim_rd_blen_o, shim_wr_blen_o;
    logic [2:0]              shim_rd_size_o, shim_wr_size_o;
    logic [SW-1:0]           shim_rd_id_o, shim_wr_id_o;
    logic                    shim_wr_req_o, shim_wr_gnt_i, shim_wr_lock_o;
    logic [DW-1:0]           shim_wr_data_o;
    logic [DW/8-1:0]         shim_wr_be_o;
    logic                    shim_rd_valid_i, shim_rd_last_i, shim_rd_exokay_i;
    logic [DW-1:0]           shim_rd_data_i;
    logic [SW-1:0]           shim_rd_id_i, shim_wr_id_i;
    logic                    shim_rd_rdy_o;
    logic                    shim_wr_valid_i, shim_wr_exokay_i, shim_wr_rdy_o;
    logic                    err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    axi_shim_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rd_req_i(rd_req_i), .rd_gnt_o(rd_gnt_o), .rd_addr_i(rd_addr_i),
        .rd_blen_i(rd_blen_i), .rd_size_i(rd_size_i), .rd_id_i(rd_id_i), .rd_lock_i(rd_lock_i),
        .wr_req_i(wr_req_i), .wr_gnt_o(wr_gnt_o), .wr_addr_i(wr_addr_i),
        .wr_blen_i(wr_blen_i), .wr_size_i(wr_size_i), .wr_id_i(wr_id_i), .wr_lock_i(wr_lock_i),
        .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
        .rd_valid_o(rd_valid_o), .rd_last_o(rd_last_o), .rd_rdy_i(rd_rdy_i),
        .rd_data_o(rd_data_o), .rd_id_o(rd_id_o), .rd_exokay_o(rd_exokay_o),
        .wr_valid_o(wr_valid_o), .wr_id_o(wr_id_o), .wr_exokay_o(wr_exokay_o),
        .shim_rd_req_o(shim_rd_req_o), .shim_rd_gnt_i(shim_rd_gnt_i),
        .shim_rd_addr_o(shim_rd_addr_o), .shim_rd_blen_o(shim_rd_blen_o),
        .shim_rd_size_o(shim_rd_size_o), .shim_rd_id_o(shim_rd_id_o), .shim_rd_lock_o(shim_rd_lock_o),
        .shim_wr_req_o(shim_wr_req_o), .shim_wr_gnt_i(shim_wr_gnt_i),
        .shim_wr_addr_o(shim_wr_addr_o), .shim_wr_blen_o(shim_wr_blen_o),
        .shim_wr_size_o(shim_wr_size_o), .shim_wr_id_o(shim_wr_id_o), .shim_wr_lock_o(shim_wr_lock_o),
        .shim_wr_data_o(shim_wr_data_o), .shim_wr_be_o(shim_wr_be_o),
        .shim_rd_valid_i(shim_rd_valid_i), .shim_rd_last_i(shim_rd_last_i),
        .shim_rd_exokay_i(shim_rd_exokay_i), .shim_rd_data_i(shim_rd_data_i),
        .shim_rd_id_i(shim_rd_id_i), .shim_rd_rdy_o(shim_rd_rdy_o),
        .shim_wr_valid_i(shim_wr_valid_i), .shim_wr_exokay_i(shim_wr_exokay_i),
        .shim_wr_id_i(shim_wr_id_i), .shim_wr_rdy_o(shim_wr_rdy_o),
        .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        rd_req_i = '0; wr_req_i = '0; rd_rdy_i = '0;
        shim_rd_gnt_i = 0; shim_wr_gnt_i = 0;
        shim_rd_valid_i = 0; shim_rd_last_i = 0; shim_rd_exokay_i = 0;
        shim_rd_data_i = '0; shim_rd_id_i = '0;
        shim_wr_valid_i = 0; shim_wr_exokay_i = 0; shim_wr_id_i = '0;
    endtask

    task automatic do_reset();
        quiet();
        rst_ni = 1'b0;
        tick(); tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        quiet();
        for (int i = 0; i < N; i++) begin
            rd_addr_i[i] = 64'h1000 * (i + 1);
            wr_addr_i[i] = 64'h8000 + 64'h100 * i;
            rd_blen_i[i] = 8'(i + 3); wr_blen_i[i] = 8'(i + 1);
            rd_size_i[i] = 3'd3; wr_size_i[i] = 3'd2;
            rd_id_i[i] = 2'd1; wr_id_i[i] = 2'd2;
            rd_lock_i[i] = 1'b0; wr_lock_i[i] = 1'b0;
            wr_data_i[i] = 64'hA5A5_0000 + 64'(i); wr_be_i[i] = 8'hFF;
        end

        // ---- reset: outputs quiet even with requests and responses present
        rd_req_i = 3'b111; wr_req_i = 3'b111; shim_rd_gnt_i = 1; shim_rd_valid_i = 1;
        #2;
        chk("rst_rd_gnt", rd_gnt_o, 0);
        chk("rst_wr_gnt", wr_gnt_o, 0);
        chk("rst_shim_rd_req", shim_rd_req_o, 0);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_err", err_o, 0);
        do_reset();

        // ---- fairness: continuous requests, shim always grants
        begin
            logic [2:0] exp_g [6];
            exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
            rd_req_i = 3'b111; shim_rd_gnt_i = 1;
            for (int k = 0; k < 6; k++) begin
                #1;
                chk($sformatf("rr_gnt%0d", k), rd_gnt_o, exp_g[k]);
                chk($sformatf("rr_id%0d", k), shim_rd_id_o[3:2], k % 3);
                tick();
            end
        end
        do_reset();

        // ---- hold: requester 1 alone, shim stalls, requester 0 joins
        rd_req_i = 3'b010; shim_rd_gnt_i = 0;
        #1;
        chk("hold_req", shim_rd_req_o, 1);
        chk("hold_addr0", shim_rd_addr_o, 64'h2000);
        chk("hold_gnt0", rd_gnt_o, 0);
        tick();
        rd_req_i = 3'b011;
        #1;
        chk("hold_addr1", shim_rd_addr_o, 64'h2000);
        chk("hold_id1", shim_rd_id_o, 4'b0101);
        tick();
        shim_rd_gnt_i = 1;
        #1;
        chk("hold_addr2", shim_rd_addr_o, 64'h2000);
        chk("hold_gnt", rd_gnt_o, 3'b010);
        tick();
        rd_req_i = 3'b001;
        #1;
        chk("hold_next", rd_gnt_o, 3'b001);
        chk("hold_next_addr", shim_rd_addr_o, 64'h1000);
        do_reset();

        // ---- throttling: 4 writes outstanding for requester 0
        wr_req_i = 3'b001; shim_wr_gnt_i = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("thr_gnt%0d", k), wr_gnt_o, 3'b001);
            tick();
        end
        #1;
        chk("thr_blocked_req", shim_wr_req_o, 0);
        chk("thr_blocked_gnt", wr_gnt_o, 0);
        tick();
        wr_req_i = 3'b101;
        #1;
        chk("thr_serve2a", wr_gnt_o, 3'b100);
        chk("thr_data2", shim_wr_data_o, 64'hA5A5_0002);
        tick();
        #1;
        chk("thr_serve2b", wr_gnt_o, 3'b100);
        tick();
        wr_req_i = 3'b001; shim_wr_valid_i = 1; shim_wr_id_i = 4'b0010; shim_wr_exokay_i = 1;
        #1;
        chk("thr_wvalid", wr_valid_o, 3'b001);
        chk("thr_wid", wr_id_o, 2);
        chk("thr_wexok", wr_exokay_o, 1);
        chk("thr_wrdy", shim_wr_rdy_o, 1);
        chk("thr_still_blk", wr_gnt_o, 0);
        tick();
        shim_wr_valid_i = 0; shim_wr_exokay_i = 0;
        #1;
        chk("thr_unblk", wr_gnt_o, 3'b001);
        chk("thr_err", err_o, 0);
        do_reset();

        // ---- read routing: one read for requester 2, 4-beat burst
        rd_req_i = 3'b100; shim_rd_gnt_i = 1;
        #1;
        chk("rt_gnt", rd_gnt_o, 3'b100);
        tick();
        rd_req_i = 0; shim_rd_gnt_i = 0;
        shim_rd_valid_i = 1; shim_rd_id_i = 4'b1001; shim_rd_data_i = 64'hDEAD_BEEF;
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 2; r++) begin
                shim_rd_last_i = (b == 3);
                rd_rdy_i = (r == 1) ? 3'b111 : 3'b011;
                #1;
                chk($sformatf("rt_valid_b%0d_r%0d", b, r), rd_valid_o, 3'b100);
                chk($sformatf("rt_rdy_b%0d_r%0d", b, r), shim_rd_rdy_o, r);
                if (b == 3) chk($sformatf("rt_last_r%0d", r), rd_last_o, 3'b100);
                tick();
            end
        end
        shim_rd_valid_i = 0;
        #1;
        chk("rt_id", rd_id_o, 1);
        chk("rt_data", rd_data_o, 64'hDEAD_BEEF);
        chk("rt_err_after_burst", err_o, 0);
        // counter is now zero: one more completion must underflow
        shim_rd_valid_i = 1; shim_rd_last_i = 1;
        tick();
        shim_rd_valid_i = 0;
        #1;
        chk("rt_cnt_zero", err_o, 1);
        do_reset();

        // ---- simultaneous grant and completion on requester 1
        rd_req_i = 3'b010; shim_rd_gnt_i = 1;
        tick();
        rd_rdy_i = 3'b010; shim_rd_valid_i = 1; shim_rd_last_i = 1; shim_rd_id_i = 4'b0100;
        #1;
        chk("sim_gnt", rd_gnt_o, 3'b010);
        tick();
        rd_req_i = 0; shim_rd_gnt_i = 0;
        tick();                                 // cnt 1 -> 0
        shim_rd_valid_i = 0;
        #1;
        chk("sim_one_left", err_o, 0);
        shim_rd_valid_i = 1;
        tick();                                 // underflow
        shim_rd_valid_i = 0;
        #1;
        chk("sim_uflow", err_o, 1);
        do_reset();

        // ---- errors: illegal index drained, sticky until reset
        shim_rd_valid_i = 1; shim_rd_last_i = 1; shim_rd_id_i = 4'b1100; rd_rdy_i = 3'b000;
        #1;
        chk("ill_valid", rd_valid_o, 0);
        chk("ill_last", rd_last_o, 0);
        chk("ill_rdy", shim_rd_rdy_o, 1);
        chk("ill_err_pre", err_o, 0);
        tick();
        shim_rd_valid_i = 0;
        #1;
        chk("ill_err", err_o, 1);
        tick(); tick();
        chk("ill_sticky", err_o, 1);
        rst_ni = 0;
        #1;
        chk("ill_clr", err_o, 0);
        tick();
        rst_ni = 1;
        // write response for a requester with nothing outstanding
        shim_wr_valid_i = 1; shim_wr_id_i = 4'b0000;
        #1;
        chk("uf_wvalid", wr_valid_o, 3'b001);
        tick();
        shim_wr_valid_i = 0;
        #1;
        chk("uf_err", err_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
